// File: rtl/left_shift_expander_pkg.sv
// -----------------------------------------------------------------------------
// left_shift_expander_pkg
//
// Shared definitions for the int8 <-> int32 conversion blocks: default lane
// and shift widths, the tile-control state encoding and the signed 32-bit
// saturation limits (the same limits the requantizer clamps to).
//
// No ports (package).
// -----------------------------------------------------------------------------
package left_shift_expander_pkg;

  localparam int DEF_IN_WIDTH    = 8;
  localparam int DEF_OUT_WIDTH   = 32;
  localparam int DEF_SHIFT_WIDTH = 5;
  localparam int DEF_LANES       = 4;
  localparam int DEF_TILE_LEN    = 64;

  // Signed saturation limits for the default output width.
  localparam logic [DEF_OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(DEF_OUT_WIDTH-1){1'b1}}};
  localparam logic [DEF_OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(DEF_OUT_WIDTH-1){1'b0}}};

  // Tile control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/left_shift_expander_lane.sv
// -----------------------------------------------------------------------------
// lane_left_shift
//
// Combinational expansion of one signed lane: sign-extend the input to
// IN_WIDTH + 2^SHIFT_WIDTH bits (wide enough that no shift amount can lose
// bits), arithmetic left shift, then reduce to OUT_WIDTH bits.
//
// Configuration macro: LEFT_SHIFT_SAT_EN
//   defined   : out-of-range results clamp to the signed OUT_WIDTH limits
//   undefined : result is the low OUT_WIDTH bits of the shifted value (wrap)
//
// Ports:
//   lane_in  [IN_WIDTH-1:0]    signed input lane
//   shamt    [SHIFT_WIDTH-1:0] left-shift amount
//   lane_out [OUT_WIDTH-1:0]   signed expanded result
// -----------------------------------------------------------------------------
module lane_left_shift
  import left_shift_expander_pkg::*;
#(
  parameter int IN_WIDTH    = DEF_IN_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic [IN_WIDTH-1:0]    lane_in,
  input  logic [SHIFT_WIDTH-1:0] shamt,
  output logic [OUT_WIDTH-1:0]   lane_out
);

  // Width that holds any input shifted by the largest shift amount.
  localparam int EXT_WIDTH = IN_WIDTH + (2 ** SHIFT_WIDTH);

  logic signed [EXT_WIDTH-1:0] ext_s;
  logic signed [EXT_WIDTH-1:0] shl_s;

  assign ext_s = {{(EXT_WIDTH-IN_WIDTH){lane_in[IN_WIDTH-1]}}, lane_in};
  assign shl_s = ext_s <<< shamt;

`ifdef LEFT_SHIFT_SAT_EN

  localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // Bits from the output sign bit upward must all match for the result to fit.
  logic [EXT_WIDTH-OUT_WIDTH:0] top_bits_s;
  logic                         fits_s;

  assign top_bits_s = shl_s[EXT_WIDTH-1:OUT_WIDTH-1];
  assign fits_s     = (&top_bits_s) | ~(|top_bits_s);

  // Clamp on overflow; the wide sign bit is the true sign of the result.
  always_comb begin
    lane_out = shl_s[OUT_WIDTH-1:0];
    if (fits_s) begin
      lane_out = shl_s[OUT_WIDTH-1:0];
    end else if (shl_s[EXT_WIDTH-1]) begin
      lane_out = SAT_MIN;
    end else begin
      lane_out = SAT_MAX;
    end
  end

`else

  // Modular wrap: upper bits are intentionally dropped.
  logic unused_hi_s;

  assign lane_out    = shl_s[OUT_WIDTH-1:0];
  assign unused_hi_s = ^shl_s[EXT_WIDTH-1:OUT_WIDTH];

`endif

endmodule

// File: rtl/left_shift_expander.sv
// -----------------------------------------------------------------------------
// left_shift_expander
//
// Streaming dequantizer: expands tiles of packed signed IN_WIDTH lanes to
// signed OUT_WIDTH lanes by an arithmetic left shift latched once per tile.
// Two-stage valid/ready pipeline (input register, result register) with a
// per-tile beat counter that tags the final beat of each tile.
//
// Configuration macro: LEFT_SHIFT_SAT_EN (saturating overflow when defined,
// modular wrap otherwise; handled inside lane_left_shift).
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   cfg_shift      shift amount, captured with cfg_load while idle
//   cfg_load       start-of-tile pulse (ignored unless idle)
//   s_valid/s_ready/s_data   input beat handshake, LANES x IN_WIDTH
//   m_valid/m_ready/m_data   output beat handshake, LANES x OUT_WIDTH
//   m_last         marks the final beat of a tile
//   busy           tile in progress (RUN or DRAIN)
// -----------------------------------------------------------------------------
module left_shift_expander
  import left_shift_expander_pkg::*;
#(
  parameter int IN_WIDTH    = DEF_IN_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
  parameter int LANES       = DEF_LANES,
  parameter int TILE_LEN    = DEF_TILE_LEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SHIFT_WIDTH-1:0]     cfg_shift,
  input  logic                       cfg_load,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [LANES*IN_WIDTH-1:0]  s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [LANES*OUT_WIDTH-1:0] m_data,
  output logic                       m_last,
  output logic                       busy
);

  localparam int              CNT_W    = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TILE_LEN - 1);

  state_e                     state_r;
  state_e                     state_nxt_s;
  logic                       busy_r;
  logic [SHIFT_WIDTH-1:0]     shift_r;
  logic [CNT_W-1:0]           cnt_r;

  logic                       s1_valid_r;
  logic                       s1_last_r;
  logic [LANES*IN_WIDTH-1:0]  s1_data_r;

  logic                       m_valid_r;
  logic                       m_last_r;
  logic [LANES*OUT_WIDTH-1:0] m_data_r;
  logic [LANES*OUT_WIDTH-1:0] lane_out_s;

  logic                       s2_adv_s;
  logic                       accept_s;
  logic                       last_beat_s;
  logic                       tile_done_s;

  // Stage 2 can take new data when empty or when its beat leaves this cycle.
  assign s2_adv_s    = ~m_valid_r | m_ready;
  // Stage 1 accepts when empty or when its beat moves into stage 2.
  assign s_ready     = (state_r == ST_RUN) & (~s1_valid_r | s2_adv_s);
  assign accept_s    = s_valid & s_ready;
  assign last_beat_s = (cnt_r == LAST_CNT);
  assign tile_done_s = m_valid_r & m_ready & m_last_r;

  // Next-state logic for tile control.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_load) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && last_beat_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (tile_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered busy flag (tracks the next state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Per-tile shift latch and beat counter; shift only loads while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= {SHIFT_WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else if ((state_r == ST_IDLE) && cfg_load) begin
      shift_r <= cfg_shift;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      cnt_r   <= cnt_r + CNT_W'(1);
    end
  end

  // Stage 1: raw input beat plus its end-of-tile tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_data_r  <= {(LANES*IN_WIDTH){1'b0}};
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_last_r  <= last_beat_s;
      s1_data_r  <= s_data;
    end else if (s1_valid_r && s2_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Shift/saturate units between stage 1 and stage 2.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_left_shift #(
      .IN_WIDTH    (IN_WIDTH),
      .OUT_WIDTH   (OUT_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_lane (
      .lane_in  (s1_data_r[i*IN_WIDTH +: IN_WIDTH]),
      .shamt    (shift_r),
      .lane_out (lane_out_s[i*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  // Stage 2: registered output beat; holds while stalled by m_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
      m_data_r  <= {(LANES*OUT_WIDTH){1'b0}};
    end else if (s2_adv_s) begin
      m_valid_r <= s1_valid_r;
      m_last_r  <= s1_valid_r & s1_last_r;
      if (s1_valid_r) begin
        m_data_r <= lane_out_s;
      end
    end
  end

  assign m_valid = m_valid_r;
  assign m_last  = m_last_r;
  assign m_data  = m_data_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_left_shift_expander.sv
// -----------------------------------------------------------------------------
// tb_left_shift_expander
//
// Random-stimulus bench with a scoreboard: the driver pushes the expected
// output beat (arithmetic reference model) on every input handshake, and a
// monitor pops and compares on every output handshake. Also checks output
// hold under backpressure, pipeline latency, busy timing and reset.
// -----------------------------------------------------------------------------
module tb_left_shift_expander;

  localparam int IW = 8;
  localparam int OW = 32;
  localparam int SW = 5;
  localparam int LN = 4;
  localparam int TL = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SW-1:0]   cfg_shift = '0;
  logic            cfg_load = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [LN*IW-1:0] s_data = '0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [LN*OW-1:0] m_data;
  logic            m_last;
  logic            busy;

  left_shift_expander #(
    .IN_WIDTH (IW), .OUT_WIDTH (OW), .SHIFT_WIDTH (SW), .LANES (LN), .TILE_LEN (TL)
  ) dut (
    .clk (clk), .rst (rst), .cfg_shift (cfg_shift), .cfg_load (cfg_load),
    .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data),
    .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data), .m_last (m_last),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LN*OW-1:0] data;
    logic             last;
    int               acc;
    bit               chk_lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   mr_mode  = 0;
  bit   busy_fall_pend = 1'b0;
  bit   prev_stall = 1'b0;
  bit   head_seen  = 1'b0;
  logic [LN*OW-1:0] prev_data;
  logic             prev_last;

  task automatic check(input string name, input logic [LN*OW-1:0] act,
                       input logic [LN*OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: value * 2^shift in wide arithmetic, then clamp or wrap.
  function automatic logic [OW-1:0] lane_model(input logic signed [IW-1:0] v, input int sh);
    longint y;
    longint lim_hi;
    longint lim_lo;
    logic [63:0] yb;
    y      = longint'(v) * (64'sd1 << sh);
    lim_hi = 64'sd2147483647;
    lim_lo = -64'sd2147483648;
    yb     = y;
`ifdef LEFT_SHIFT_SAT_EN
    if (y > lim_hi) return 32'h7FFF_FFFF;
    if (y < lim_lo) return 32'h8000_0000;
    return yb[31:0];
`else
    if (lim_hi < lim_lo) return 32'h0000_0000;
    return yb[31:0];
`endif
  endfunction

  function automatic logic [LN*OW-1:0] expect_vec(input logic [LN*IW-1:0] d, input int sh);
    logic [LN*OW-1:0] r;
    r = '0;
    for (int i = 0; i < LN; i++) r[i*OW +: OW] = lane_model(d[i*IW +: IW], sh);
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: always high, or about 30% duty.
  always @(posedge clk) begin
    #1;
    if (mr_mode == 0) m_ready = 1'b1;
    else              m_ready = ($urandom_range(0, 9) < 3);
  end

  // Monitor / scoreboard checker.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall     = 1'b0;
      head_seen      = 1'b0;
      busy_fall_pend = 1'b0;
    end else begin
      if (busy_fall_pend) begin
        check("busy_fall", busy, 1'b0);
        busy_fall_pend = 1'b0;
      end
      if (prev_stall) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h with empty scoreboard", m_data);
        end else begin
          if (!head_seen) begin
            head_seen = 1'b1;
            if (exp_q[0].chk_lat) check("latency", cyc - exp_q[0].acc, 2);
          end
          if (m_ready) begin
            mon_e = exp_q.pop_front();
            head_seen = 1'b0;
            check("data", m_data, mon_e.data);
            check("last", m_last, mon_e.last);
            if (m_last) begin
              check("busy_at_last", busy, 1'b1);
              busy_fall_pend = 1'b1;
            end
          end
        end
      end
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // Drive one tile; called at posedge+1 with the DUT idle. Beat 0 is
  // presented together with cfg_load and, if use_first, checked against
  // a hand-computed constant.
  task automatic run_tile(input int shift, input int nbeats,
                          input logic [LN*IW-1:0] first_vec, input bit use_first,
                          input logic [LN*OW-1:0] first_exp, input bit mid_cfg);
    int   idx;
    int   guard;
    bit   acc;
    bit   first;
    exp_t e;
    idx   = 0;
    guard = 0;
    first = 1'b1;
    cfg_shift = SW'(shift);
    cfg_load  = 1'b1;
    s_valid   = 1'b1;
    s_data    = first_vec;
    @(negedge clk);
    check("idle_s_ready", s_ready, 1'b0);
    check("idle_busy", busy, 1'b0);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    while (idx < nbeats && guard < 4000) begin
      if (!s_valid && ($urandom_range(0, 3) != 0)) begin
        s_valid = 1'b1;
        s_data  = $urandom();
      end
      if (mid_cfg && idx == 20) begin
        cfg_load  = 1'b1;
        cfg_shift = 5'd3;
      end else begin
        cfg_load  = 1'b0;
      end
      @(negedge clk);
      if (first) begin
        check("busy_rise", busy, 1'b1);
        first = 1'b0;
      end
      acc = s_valid & s_ready;
      if (acc) begin
        e.data    = (idx == 0 && use_first) ? first_exp : expect_vec(s_data, shift);
        e.last    = (idx == TL - 1);
        e.acc     = cyc;
        e.chk_lat = (mr_mode == 0);
        exp_q.push_back(e);
        idx++;
      end
      guard++;
      @(posedge clk); #1;
      if (acc) s_valid = 1'b0;
    end
    if (idx < nbeats) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: accepted %0d of %0d beats", idx, nbeats);
    end
    s_valid  = 1'b0;
    cfg_load = 1'b0;
  endtask

  // Wait (bounded) for the scoreboard to empty and the block to go idle.
  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding, busy %b", exp_q.size(), busy);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [LN*OW-1:0] sat_exp;
`ifdef LEFT_SHIFT_SAT_EN
    sat_exp = {32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
`else
    sat_exp = {32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, '0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Plain sign extension.
    mr_mode = 0;
    run_tile(0, TL, 32'hFF00_807F, 1'b1,
             {32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FF80, 32'h0000_007F}, 1'b0);
    wait_idle();

    // Scaling by 256.
    run_tile(8, TL, 32'h9C64_FF01, 1'b1,
             {32'hFFFF_9C00, 32'h0000_6400, 32'hFFFF_FF00, 32'h0000_0100}, 1'b0);
    wait_idle();

    // Largest shift: overflow handling.
    run_tile(31, TL, 32'h7F00_FF01, 1'b1, sat_exp, 1'b0);
    wait_idle();

    // Backpressure with an ignored mid-tile cfg_load.
    mr_mode = 1;
    run_tile(5, TL, $urandom(), 1'b0, '0, 1'b1);
    wait_idle();
    run_tile(20, TL, $urandom(), 1'b0, '0, 1'b0);
    wait_idle();

    // Reset after 10 beats, then a fresh full tile.
    run_tile(6, 10, $urandom(), 1'b0, '0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_s_ready", s_ready, 1'b0);
    check("midrst_m_valid", m_valid, 1'b0);
    check("midrst_m_data", m_data, '0);
    check("midrst_m_last", m_last, 1'b0);
    check("midrst_busy", busy, 1'b0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_tile(2, TL, $urandom(), 1'b0, '0, 1'b0);
    wait_idle();

    // Random shift, full-rate output.
    mr_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    run_tile($urandom_range(0, 31), TL, $urandom(), 1'b0, '0, 1'b0);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
